// File: rtl/timer_counter_dev.sv
// Memory-mapped down-counting timer: one-shot or auto-reload, maskable registered irq; reads are combinational.
// Writes land on the next clk edge, no backpressure; define COUNTER_STATUS_EN for the addr 3 status/clear register.
module timer_counter_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [31:0] din,
  input  logic        we,
  input  logic [3:0]  be,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CNT  = 2'd1;
  localparam logic [1:0] ST_INT  = 2'd2;

  logic [1:0]       state;
  logic             en;
  logic [1:0]       mode;
  logic             im;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             irq_pending;

  logic [31:0] preset_ext;
  logic [31:0] count_ext;
  logic [31:0] preset_merged;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        pend_clr;
  logic        reload_mode;

  always_comb begin
    preset_ext = '0;
    preset_ext[CNT_W-1:0] = preset;
    count_ext = '0;
    count_ext[CNT_W-1:0] = count;
    preset_merged = '0;
    for (int i = 0; i < 4; i++) begin
      preset_merged[8*i +: 8] = be[i] ? din[8*i +: 8] : preset_ext[8*i +: 8];
    end
  end

  assign ctrl_wr     = we && (addr == 2'd0) && be[0];
  assign preset_wr   = we && (addr == 2'd1);
  assign reload_mode = (mode == 2'b01);

`ifdef COUNTER_STATUS_EN
  assign pend_clr = we && (addr == 2'd3) && be[0] && din[0];
`else
  // Any CTRL or PRESET access acknowledges a held one-shot interrupt.
  assign pend_clr = we && ((addr == 2'd0) || (addr == 2'd1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      en          <= 1'b0;
      mode        <= 2'b00;
      im          <= 1'b0;
      preset      <= '0;
      count       <= '0;
      irq_pending <= 1'b0;
      irq         <= 1'b0;
    end else begin
      irq <= irq_pending & im;

      // A bus write to CTRL overrides the FSM clearing EN at the end of a one-shot.
      if (ctrl_wr) begin
        {im, mode, en} <= din[3:0];
      end else if ((state == ST_INT) && !reload_mode) begin
        en <= 1'b0;
      end

      if (preset_wr) begin
        preset <= preset_merged[CNT_W-1:0];
      end

      // Setting in INT takes priority over any clear in the same cycle.
      if (state == ST_INT) begin
        irq_pending <= 1'b1;
      end else if (pend_clr || reload_mode) begin
        irq_pending <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (en) begin
            count <= preset;
            state <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (count > CNT_W'(1)) begin
            count <= count - CNT_W'(1);
          end else begin
            count <= '0;
            state <= ST_INT;
          end
        end
        ST_INT: begin
          if (reload_mode) begin
            count <= preset;
            state <= ST_CNT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      2'd0: dout = {28'b0, im, mode, en};
      2'd1: dout = preset_ext;
      2'd2: dout = count_ext;
      default: begin
`ifdef COUNTER_STATUS_EN
        dout = {28'b0, state, im, irq_pending};
`else
        dout = '0;
`endif
      end
    endcase
  end

endmodule
